// File: rtl/skin_bg_classifier.sv
`default_nettype none
// ============================================================================
// Module   : skin_bg_classifier
// Purpose  : Per-pixel object classifier for a YCbCr stream. A pixel is a
//            "skin" hit when Y/Cb/Cr fall strictly inside a fixed window, and
//            a "background" hit when its luma differs from a stored
//            background frame by more than BG_THRESH. The two hits are
//            combined according to a frame-latched mode.
//            Fixed 2-cycle latency, no backpressure.
// Ports    : clk, rst (async, active-low)
//            in_valid, in_sof, luma_ch, cb_ch, cr_ch, mode, bg_recapture
//            out_valid, object_image, out_sof, bg_ready, frame_err
// Revision : 1.0 - initial release
// ============================================================================
module skin_bg_classifier #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 19200,
  parameter int CNT_W        = 15,
  parameter int Y_MIN        = 80,
  parameter int CB_MIN       = 125,
  parameter int CB_MAX       = 180,
  parameter int CR_MIN       = 190,
  parameter int CR_MAX       = 225,
  parameter int BG_THRESH    = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] luma_ch,
  input  logic [PIX_W-1:0] cb_ch,
  input  logic [PIX_W-1:0] cr_ch,
  input  logic [1:0]       mode,
  input  logic             bg_recapture,
  output logic             out_valid,
  output logic             object_image,
  output logic             out_sof,
  output logic             bg_ready,
  output logic             frame_err
);

  localparam logic [1:0] S_WAIT_SOF = 2'd0;
  localparam logic [1:0] S_CAPTURE  = 2'd1;
  localparam logic [1:0] S_COMPARE  = 2'd2;

  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [PIX_W-1:0] c_Y_MIN   = PIX_W'(Y_MIN);
  localparam logic [PIX_W-1:0] c_CB_MIN  = PIX_W'(CB_MIN);
  localparam logic [PIX_W-1:0] c_CB_MAX  = PIX_W'(CB_MAX);
  localparam logic [PIX_W-1:0] c_CR_MIN  = PIX_W'(CR_MIN);
  localparam logic [PIX_W-1:0] c_CR_MAX  = PIX_W'(CR_MAX);
  localparam logic [PIX_W:0]   c_THRESH  = (PIX_W+1)'(BG_THRESH);

  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_bg_ready, w_bg_ready_nx;
  logic             r_frame_err, w_err_nx;
  logic [1:0]       r_mode;

  logic [CNT_W-1:0] w_addr;
  logic [CNT_W-1:0] w_addr_inc;
  logic             w_wr_en;
  logic             w_skin;
  logic [1:0]       w_mode_eff;

  // Stage-1 pipeline registers (pixel accepted one cycle ago)
  logic             r1_valid, r1_sof, r1_skin, r1_bgr;
  logic [1:0]       r1_mode;
  logic [PIX_W-1:0] r1_y;
  logic [PIX_W-1:0] r_bg_rd;

  // Stage-2 / output registers
  logic             r_out_valid, r_out_sof, r_obj;

  logic [PIX_W-1:0] r_mem [FRAME_PIXELS];

  logic [PIX_W:0]   w_a, w_b, w_diff;
  logic             w_bg_hit, w_obj;

  // An in_sof pixel always maps to address 0; otherwise the counter holds
  // the address of the pixel being accepted.
  assign w_addr     = in_sof ? '0 : r_cnt;
  assign w_addr_inc = (w_addr == c_LAST) ? '0 : (w_addr + CNT_W'(1));
  assign w_mode_eff = in_sof ? mode : r_mode;
  assign w_wr_en    = in_valid &&
                      ((r_state == S_WAIT_SOF && in_sof) || r_state == S_CAPTURE);

  assign w_skin = (luma_ch > c_Y_MIN) &&
                  (cb_ch > c_CB_MIN) && (cb_ch < c_CB_MAX) &&
                  (cr_ch > c_CR_MIN) && (cr_ch < c_CR_MAX);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_bg_ready_nx = r_bg_ready;
    w_err_nx      = 1'b0;
    if (bg_recapture) begin
      w_state_nx    = S_WAIT_SOF;
      w_cnt_nx      = '0;
      w_bg_ready_nx = 1'b0;
    end else if (in_valid) begin
      case (r_state)
        S_WAIT_SOF, S_CAPTURE: begin
          if (r_state == S_WAIT_SOF && !in_sof) begin
            w_state_nx = S_WAIT_SOF;
          end else begin
            // in_sof during capture means the previous attempt was short
            w_err_nx = (r_state == S_CAPTURE) && in_sof;
            if (w_addr == c_LAST) begin
              w_state_nx    = S_COMPARE;
              w_cnt_nx      = '0;
              w_bg_ready_nx = 1'b1;
            end else begin
              w_state_nx = S_CAPTURE;
              w_cnt_nx   = w_addr + CNT_W'(1);
            end
          end
        end
        S_COMPARE: begin
          // short frame: sof arrives mid-frame; long frame: wrap without sof
          w_err_nx = (in_sof && r_cnt != '0) || (!in_sof && r_cnt == '0);
          w_cnt_nx = w_addr_inc;
        end
        default: begin
          w_state_nx = S_WAIT_SOF;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_WAIT_SOF;
      r_cnt       <= '0;
      r_bg_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      r_mode      <= 2'b00;
      r1_valid    <= 1'b0;
      r1_sof      <= 1'b0;
      r1_skin     <= 1'b0;
      r1_bgr      <= 1'b0;
      r1_mode     <= 2'b00;
      r1_y        <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_obj       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bg_ready  <= w_bg_ready_nx;
      r_frame_err <= w_err_nx;
      if (in_valid && in_sof) begin
        r_mode <= mode;
      end
      r1_valid    <= in_valid;
      r1_sof      <= in_valid && in_sof;
      r1_skin     <= w_skin;
      r1_bgr      <= r_bg_ready;   // classification uses pre-recapture state
      r1_mode     <= w_mode_eff;
      r1_y        <= luma_ch;
      r_out_valid <= r1_valid;
      r_out_sof   <= r1_sof;
      r_obj       <= r1_valid && w_obj;
    end
  end

  // Background store: no reset, contents are gated by bg_ready.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_addr] <= luma_ch;
    end
    r_bg_rd <= r_mem[w_addr];
  end

  // Absolute difference at PIX_W+1 bits so neither direction wraps.
  assign w_a      = {1'b0, r_bg_rd};
  assign w_b      = {1'b0, r1_y};
  assign w_diff   = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  assign w_bg_hit = r1_bgr && (w_diff > c_THRESH);

  always_comb begin
    case (r1_mode)
      2'b00:   w_obj = r1_skin;
      2'b01:   w_obj = w_bg_hit;
      2'b10:   w_obj = r1_skin && w_bg_hit;
      default: w_obj = r1_skin || w_bg_hit;
    endcase
  end

  assign out_valid    = r_out_valid;
  assign out_sof      = r_out_sof;
  assign object_image = r_obj;
  assign bg_ready     = r_bg_ready;
  assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: doc/skin_bg_classifier.md
SKIN_BG_CLASSIFIER -- requirements
Module: skin_bg_classifier

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning Y/Cb/Cr channel width.
REQ-002 The block SHALL have parameter FRAME_PIXELS, default 19200, meaning pixels per frame and background-store depth.
REQ-003 The block SHALL have parameter CNT_W, default 15, meaning pixel-counter width, with 2^CNT_W >= FRAME_PIXELS.
REQ-004 The block SHALL have parameters Y_MIN=80, CB_MIN=125, CB_MAX=180, CR_MIN=190, CR_MAX=225, meaning strict skin-window bounds.
REQ-005 The block SHALL have parameter BG_THRESH, default 120, meaning the background-difference threshold.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the pixel qualifier.
REQ-009 The block SHALL have port in_sof, input, 1 bit, meaning first pixel of frame, valid only with in_valid.
REQ-010 The block SHALL have ports luma_ch, cb_ch, cr_ch, input, PIX_W bits each, meaning pixel channels.
REQ-011 The block SHALL have port mode, input, 2 bits: 00 skin only, 01 background only, 10 skin AND background, 11 skin OR background.
REQ-012 The block SHALL have port bg_recapture, input, 1 bit, meaning a single-cycle request to relearn the background.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning object_image and out_sof are valid.
REQ-014 The block SHALL have port object_image, output, 1 bit, meaning the pixel classification.
REQ-015 The block SHALL have port out_sof, output, 1 bit, meaning in_sof delayed to align with object_image.
REQ-016 The block SHALL have port bg_ready, output, 1 bit, meaning a full background frame is stored.
REQ-017 The block SHALL have port frame_err, output, 1 bit, meaning a one-cycle pulse on a frame-length violation.

Function
REQ-018 The FSM SHALL have states WAIT_SOF, CAPTURE, COMPARE; state changes only on accepted pixels (in_valid=1) or on bg_recapture.
REQ-019 In WAIT_SOF, pixels with in_sof=0 SHALL be ignored for storage; in_sof=1 SHALL store at address 0, set counter=1, and enter CAPTURE.
REQ-020 In CAPTURE, each accepted pixel SHALL write luma_ch at address counter; on writing address FRAME_PIXELS-1, the FSM SHALL enter COMPARE, set bg_ready=1, and set counter=0.
REQ-021 In CAPTURE, in_sof=1 before FRAME_PIXELS pixels SHALL pulse frame_err and restart capture at address 0.
REQ-022 In COMPARE, the counter SHALL be forced to 0 on in_sof=1 and otherwise increment per accepted pixel, wrapping FRAME_PIXELS-1 -> 0.
REQ-023 In COMPARE, in_sof=1 with counter != 0 (short frame) or wrap to 0 without in_sof (long frame) SHALL pulse frame_err one cycle after the offending pixel.
REQ-024 bg_recapture=1 in any state SHALL clear bg_ready and enter WAIT_SOF next cycle; a pixel presented in the same cycle SHALL be classified under the old state.
REQ-025 The background store SHALL be FRAME_PIXELS x PIX_W with synchronous read; reads and writes never address >= FRAME_PIXELS.
REQ-026 skin_hit SHALL equal (Y > Y_MIN) AND (CB_MIN < Cb < CB_MAX) AND (CR_MIN < Cr < CR_MAX), all unsigned.
REQ-027 bg_hit SHALL equal |bg - Y| > BG_THRESH, computed at PIX_W+1 bits with no wrap, and SHALL be 0 when bg_ready=0.
REQ-028 object_image SHALL be mode 00: skin_hit; 01: bg_hit; 10: skin_hit AND bg_hit; 11: skin_hit OR bg_hit.
REQ-029 mode SHALL be sampled on pixels with in_sof=1 and held for the rest of the frame.
REQ-030 Latency SHALL be exactly 2 cycles: out_valid, out_sof, and object_image reflect the pixel accepted 2 cycles earlier.
REQ-031 While out_valid=0, object_image SHALL be 0; there is no backpressure and bubbles pass unchanged.

Reset
REQ-032 On rst=0, the block SHALL asynchronously force: FSM to WAIT_SOF, counter=0, latched mode=00, bg_ready=0, out_valid=0, out_sof=0, object_image=0, frame_err=0, and clear the pipeline valids.
REQ-033 Background-store contents SHALL NOT be reset; bg_ready=0 guarantees they are unused until recaptured.
REQ-034 Reset asserted mid-frame SHALL abort capture or compare; the first pixel after release SHALL be treated as in WAIT_SOF.

Verification
REQ-035 Mode 00, pixel Y=81, Cb=126, Cr=191 -> object_image=1 after 2 cycles; Y=80, same Cb/Cr -> 0 (strict bounds).
REQ-036 Mode 01, capture a frame of Y=200, then a frame of Y=70 (diff 130) -> all 1; Y=80 (diff 120) -> all 0; bg=20, Y=150 (diff 130) -> 1 (no underflow).
REQ-037 FRAME_PIXELS=16: capture 16 pixels -> bg_ready rises after pixel 16; a 15-pixel compare frame -> frame_err pulse at the next in_sof; a 17-pixel frame -> pulse at the wrap.
REQ-038 Mode 10 vs 11 on a pixel with skin_hit=1, bg_hit=0 -> 0 vs 1; a mode change mid-frame has no effect until the next in_sof.
REQ-039 bg_recapture mid-compare -> bg_ready=0 next cycle and bg-mode outputs 0; capture restarts at the next in_sof.
REQ-040 rst low mid-capture with in_valid toggling -> all outputs 0 immediately; after release, pixels before the first in_sof are not stored.
